// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit for the 5-stage pipeline.
// Provides EX-stage operand forwarding selects and load-use stall detection.
// Holds a scoreboard for one outstanding multi-cycle multiplier op, which
// gives multiplier stalls and ID-stage forwarding of the multiplier result.
// Also keeps a saturating count of stall cycles.
module fwd_hazard_unit #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // EX-stage forwarding sources
    input  logic [NUM_SRC*ADDR_W-1:0] ex_src_addr_i,
    input  logic [ADDR_W-1:0]         ex_mem_wr_addr_i,
    input  logic                      ex_mem_reg_write_i,
    input  logic [ADDR_W-1:0]         mem_wb_wr_addr_i,
    input  logic                      mem_wb_reg_write_i,
    // ID-stage instruction
    input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr_i,
    input  logic [NUM_SRC-1:0]        id_src_used_i,
    input  logic [ADDR_W-1:0]         id_wr_addr_i,
    input  logic                      id_reg_write_i,
    input  logic                      id_is_mul_i,
    // ID/EX instruction
    input  logic [ADDR_W-1:0]         id_ex_wr_addr_i,
    input  logic                      id_ex_reg_write_i,
    input  logic                      id_ex_is_load_i,
    // Multiplier issue
    input  logic                      mul_start_i,
    input  logic [ADDR_W-1:0]         mul_dst_i,
    // Outputs
    output logic [NUM_SRC*2-1:0]      fwd_sel_o,
    output logic [NUM_SRC-1:0]        id_fwd_mul_o,
    output logic                      stall_o,
    output logic                      mul_busy_o,
    output logic                      mul_done_o,
    output logic [ADDR_W-1:0]         mul_wb_addr_o,
    output logic                      mul_overrun_o,
    output logic [CNT_W-1:0]          stall_cnt_o
);

    // A latency of 1 would need DONE in the cycle right after the start,
    // which this scoreboard cannot express.
    if (MUL_LAT < 2) begin : gen_bad_lat
        $error("fwd_hazard_unit: MUL_LAT must be >= 2");
    end

    // Remaining-cycles counter only ever holds MUL_LAT-1 down to 1.
    localparam int unsigned LatW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
    localparam logic [LatW-1:0] LatInit = LatW'(MUL_LAT - 1);
    localparam logic [LatW-1:0] LatOne  = LatW'(1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LatW-1:0]   lat_cnt_q, lat_cnt_d;
    logic              overrun_q, overrun_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic              load_use_stall;
    logic              mul_raw_hit;
    logic              mul_waw_hit;
    logic              mul_stall;
    logic              dst_nz;

    // EX operand forwarding: EX/MEM has priority over MEM/WB, r0 never forwards.
    always_comb begin
        fwd_sel_o = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ex_mem_reg_write_i && (ex_mem_wr_addr_i != '0) &&
                (ex_mem_wr_addr_i == ex_src_addr_i[i*ADDR_W +: ADDR_W])) begin
                fwd_sel_o[i*2 +: 2] = 2'b10;
            end else if (mem_wb_reg_write_i && (mem_wb_wr_addr_i != '0) &&
                         (mem_wb_wr_addr_i == ex_src_addr_i[i*ADDR_W +: ADDR_W])) begin
                fwd_sel_o[i*2 +: 2] = 2'b01;
            end
        end
    end

    // Load-use detection against the load sitting in ID/EX.
    always_comb begin
        load_use_stall = 1'b0;
        if (id_ex_is_load_i && id_ex_reg_write_i && (id_ex_wr_addr_i != '0)) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (id_src_used_i[i] &&
                    (id_src_addr_i[i*ADDR_W +: ADDR_W] == id_ex_wr_addr_i)) begin
                    load_use_stall = 1'b1;
                end
            end
        end
    end

    // ID-side comparisons against the scoreboarded multiplier destination.
    always_comb begin
        dst_nz       = (dst_q != '0);
        mul_raw_hit  = 1'b0;
        id_fwd_mul_o = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_used_i[i] && dst_nz &&
                (id_src_addr_i[i*ADDR_W +: ADDR_W] == dst_q)) begin
                mul_raw_hit = 1'b1;
                // The result is on the writeback path in DONE, so ID can take it directly.
                id_fwd_mul_o[i] = (state_q == StDone);
            end
        end
        mul_waw_hit = id_reg_write_i && dst_nz && (id_wr_addr_i == dst_q);
        mul_stall   = (state_q == StRun) && (mul_raw_hit || mul_waw_hit || id_is_mul_i);
        stall_o     = load_use_stall || mul_stall;
    end

    // Scoreboard next state: accept in IDLE/DONE, count down in RUN.
    always_comb begin
        state_d   = state_q;
        dst_d     = dst_q;
        lat_cnt_d = lat_cnt_q;
        overrun_d = overrun_q;
        case (state_q)
            StIdle, StDone: begin
                if (mul_start_i) begin
                    state_d   = StRun;
                    dst_d     = mul_dst_i;
                    lat_cnt_d = LatInit;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                // A second op cannot be tracked; drop it and flag the overrun.
                if (mul_start_i) begin
                    overrun_d = 1'b1;
                end
                if (lat_cnt_q == LatOne) begin
                    state_d = StDone;
                end else begin
                    lat_cnt_d = lat_cnt_q - LatOne;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Saturating stall-cycle counter next value.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset aborts any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            dst_q       <= '0;
            lat_cnt_q   <= '0;
            overrun_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            dst_q       <= dst_d;
            lat_cnt_q   <= lat_cnt_d;
            overrun_q   <= overrun_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Outputs decoded from the scoreboard state.
    always_comb begin
        mul_busy_o    = (state_q == StRun);
        mul_done_o    = (state_q == StDone);
        mul_wb_addr_o = (state_q == StDone) ? dst_q : '0;
        mul_overrun_o = overrun_q;
        stall_cnt_o   = stall_cnt_q;
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios plus a
// randomized run against a cycle-timestamp reference model.
module tb_fwd_hazard_unit;

    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned NUM_SRC = 2;
    localparam int unsigned MUL_LAT = 4;
    localparam int unsigned CNT_W   = 4;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_SRC*ADDR_W-1:0] ex_src_addr;
    logic [ADDR_W-1:0]         ex_mem_wr_addr;
    logic                      ex_mem_reg_write;
    logic [ADDR_W-1:0]         mem_wb_wr_addr;
    logic                      mem_wb_reg_write;
    logic [NUM_SRC*ADDR_W-1:0] id_src_addr;
    logic [NUM_SRC-1:0]        id_src_used;
    logic [ADDR_W-1:0]         id_wr_addr;
    logic                      id_reg_write;
    logic                      id_is_mul;
    logic [ADDR_W-1:0]         id_ex_wr_addr;
    logic                      id_ex_reg_write;
    logic                      id_ex_is_load;
    logic                      mul_start;
    logic [ADDR_W-1:0]         mul_dst;
    logic [NUM_SRC*2-1:0]      fwd_sel;
    logic [NUM_SRC-1:0]        id_fwd_mul;
    logic                      stall;
    logic                      mul_busy;
    logic                      mul_done;
    logic [ADDR_W-1:0]         mul_wb_addr;
    logic                      mul_overrun;
    logic [CNT_W-1:0]          stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    fwd_hazard_unit #(
        .ADDR_W (ADDR_W),
        .NUM_SRC(NUM_SRC),
        .MUL_LAT(MUL_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ex_src_addr_i     (ex_src_addr),
        .ex_mem_wr_addr_i  (ex_mem_wr_addr),
        .ex_mem_reg_write_i(ex_mem_reg_write),
        .mem_wb_wr_addr_i  (mem_wb_wr_addr),
        .mem_wb_reg_write_i(mem_wb_reg_write),
        .id_src_addr_i     (id_src_addr),
        .id_src_used_i     (id_src_used),
        .id_wr_addr_i      (id_wr_addr),
        .id_reg_write_i    (id_reg_write),
        .id_is_mul_i       (id_is_mul),
        .id_ex_wr_addr_i   (id_ex_wr_addr),
        .id_ex_reg_write_i (id_ex_reg_write),
        .id_ex_is_load_i   (id_ex_is_load),
        .mul_start_i       (mul_start),
        .mul_dst_i         (mul_dst),
        .fwd_sel_o         (fwd_sel),
        .id_fwd_mul_o      (id_fwd_mul),
        .stall_o           (stall),
        .mul_busy_o        (mul_busy),
        .mul_done_o        (mul_done),
        .mul_wb_addr_o     (mul_wb_addr),
        .mul_overrun_o     (mul_overrun),
        .stall_cnt_o       (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        ex_src_addr      = '0;
        ex_mem_wr_addr   = '0;
        ex_mem_reg_write = 1'b0;
        mem_wb_wr_addr   = '0;
        mem_wb_reg_write = 1'b0;
        id_src_addr      = '0;
        id_src_used      = '0;
        id_wr_addr       = '0;
        id_reg_write     = 1'b0;
        id_is_mul        = 1'b0;
        id_ex_wr_addr    = '0;
        id_ex_reg_write  = 1'b0;
        id_ex_is_load    = 1'b0;
        mul_start        = 1'b0;
        mul_dst          = '0;
    endtask

    // Advance one cycle; inputs are changed and outputs sampled 1 time unit after posedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b1;
        tick();
        // Get some state going, then assert reset asynchronously.
        mul_start = 1'b1;
        mul_dst   = 5'd4;
        tick();
        mul_start = 1'b1;
        tick();
        mul_start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mul_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", mul_busy);
        end
        n_checks++;
        if (mul_done !== 1'b0 || mul_wb_addr !== '0) begin
            n_fail++; $display("FAIL reset_done: got %b/%0d want 0/0", mul_done, mul_wb_addr);
        end
        n_checks++;
        if (mul_overrun !== 1'b0 || stall_cnt !== '0) begin
            n_fail++; $display("FAIL reset_regs: got ovr %b cnt %0d want 0/0", mul_overrun, stall_cnt);
        end
        n_checks++;
        if (stall !== 1'b0 || fwd_sel !== '0 || id_fwd_mul !== '0) begin
            n_fail++; $display("FAIL reset_comb: got stall %b fwd %b idf %b want 0", stall, fwd_sel, id_fwd_mul);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fwd();
        do_reset();
        ex_mem_wr_addr = 5'd5; ex_mem_reg_write = 1'b1;
        mem_wb_wr_addr = 5'd5; mem_wb_reg_write = 1'b1;
        ex_src_addr    = {5'd0, 5'd5};
        #1;
        n_checks++;
        if (fwd_sel !== 4'b0010) begin
            n_fail++; $display("FAIL fwd_double: got %b want 0010", fwd_sel);
        end
        ex_mem_reg_write = 1'b0;
        #1;
        n_checks++;
        if (fwd_sel !== 4'b0001) begin
            n_fail++; $display("FAIL fwd_memwb: got %b want 0001", fwd_sel);
        end
        ex_mem_wr_addr = 5'd0; mem_wb_wr_addr = 5'd0; ex_mem_reg_write = 1'b1;
        ex_src_addr    = {5'd0, 5'd0};
        #1;
        n_checks++;
        if (fwd_sel !== 4'b0000) begin
            n_fail++; $display("FAIL fwd_r0: got %b want 0000", fwd_sel);
        end
        // Operand 1 from EX/MEM, operand 0 from MEM/WB.
        ex_mem_wr_addr = 5'd12; mem_wb_wr_addr = 5'd3;
        ex_src_addr    = {5'd12, 5'd3};
        #1;
        n_checks++;
        if (fwd_sel !== 4'b1001) begin
            n_fail++; $display("FAIL fwd_split: got %b want 1001", fwd_sel);
        end
        idle_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        id_ex_is_load = 1'b1; id_ex_reg_write = 1'b1; id_ex_wr_addr = 5'd7;
        id_src_addr   = {5'd7, 5'd2}; id_src_used = 2'b10;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL lu_stall: got %b want 1", stall);
        end
        tick();
        // Bubble now in ID/EX.
        id_ex_is_load = 1'b0; id_ex_reg_write = 1'b0; id_ex_wr_addr = 5'd0;
        #1;
        n_checks++;
        if (stall !== 1'b0 || stall_cnt !== 4'd1) begin
            n_fail++; $display("FAIL lu_one_cycle: got stall %b cnt %0d want 0/1", stall, stall_cnt);
        end
        id_ex_is_load = 1'b1; id_ex_reg_write = 1'b1; id_ex_wr_addr = 5'd7;
        id_src_used   = 2'b01;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL lu_unused: got %b want 0", stall);
        end
        id_ex_wr_addr = 5'd0; id_src_addr = {5'd0, 5'd0}; id_src_used = 2'b11;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL lu_r0: got %b want 0", stall);
        end
        idle_inputs();
    endtask

    task automatic test_mul_basic();
        do_reset();
        mul_start = 1'b1; mul_dst = 5'd9;
        id_src_addr = {5'd0, 5'd9}; id_src_used = 2'b01;
        #1;
        n_checks++;
        if (stall !== 1'b0 || mul_busy !== 1'b0) begin
            n_fail++; $display("FAIL mul_c0: got stall %b busy %b want 0/0", stall, mul_busy);
        end
        for (int c = 1; c <= 5; c++) begin
            tick();
            mul_start = 1'b0;
            #1;
            n_checks++;
            if (mul_busy !== (c <= 3) || mul_done !== (c == 4) ||
                mul_wb_addr !== ((c == 4) ? 5'd9 : 5'd0)) begin
                n_fail++;
                $display("FAIL mul_timing c%0d: got busy %b done %b wb %0d", c, mul_busy, mul_done, mul_wb_addr);
            end
            n_checks++;
            if (stall !== (c <= 3) || id_fwd_mul !== ((c == 4) ? 2'b01 : 2'b00)) begin
                n_fail++; $display("FAIL mul_raw c%0d: got stall %b idf %b", c, stall, id_fwd_mul);
            end
        end
        n_checks++;
        if (stall_cnt !== 4'd3) begin
            n_fail++; $display("FAIL mul_stall_cnt: got %0d want 3", stall_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        do_reset();
        mul_start = 1'b1; mul_dst = 5'd5;
        for (int c = 1; c <= 9; c++) begin
            tick();
            mul_start = (c == 4);
            mul_dst   = (c == 4) ? 5'd3 : 5'd0;
            #1;
            n_checks++;
            if (mul_done !== (c == 4 || c == 8) ||
                mul_wb_addr !== ((c == 4) ? 5'd5 : (c == 8) ? 5'd3 : 5'd0) ||
                mul_busy !== ((c >= 1 && c <= 3) || (c >= 5 && c <= 7))) begin
                n_fail++;
                $display("FAIL b2b c%0d: got done %b wb %0d busy %b", c, mul_done, mul_wb_addr, mul_busy);
            end
        end
        n_checks++;
        if (mul_overrun !== 1'b0) begin
            n_fail++; $display("FAIL b2b_no_overrun: got %b want 0", mul_overrun);
        end
        idle_inputs();
    endtask

    task automatic test_overrun();
        do_reset();
        mul_start = 1'b1; mul_dst = 5'd6;
        for (int c = 1; c <= 6; c++) begin
            tick();
            mul_start = (c == 2);
            mul_dst   = (c == 2) ? 5'd12 : 5'd0;
            #1;
            n_checks++;
            if (mul_done !== (c == 4) || mul_wb_addr !== ((c == 4) ? 5'd6 : 5'd0) ||
                mul_busy !== (c <= 3)) begin
                n_fail++;
                $display("FAIL ovr_ignored c%0d: got done %b wb %0d busy %b", c, mul_done, mul_wb_addr, mul_busy);
            end
        end
        n_checks++;
        if (mul_overrun !== 1'b1) begin
            n_fail++; $display("FAIL ovr_sticky: got %b want 1", mul_overrun);
        end
        idle_inputs();
    endtask

    task automatic test_waw_struct();
        do_reset();
        mul_start = 1'b1; mul_dst = 5'd10;
        tick();
        mul_start = 1'b0;
        id_wr_addr = 5'd10; id_reg_write = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL waw: got %b want 1", stall);
        end
        id_wr_addr = 5'd11;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL waw_miss: got %b want 0", stall);
        end
        id_is_mul = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL struct: got %b want 1", stall);
        end
        // Op to r0: no RAW/WAW, structural still applies.
        do_reset();
        mul_start = 1'b1; mul_dst = 5'd0;
        tick();
        mul_start = 1'b0;
        id_wr_addr = 5'd0; id_reg_write = 1'b1; id_src_addr = '0; id_src_used = 2'b11;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL mul_r0: got %b want 0", stall);
        end
        id_is_mul = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL struct_r0: got %b want 1", stall);
        end
        idle_inputs();
    endtask

    task automatic test_stall_sat();
        do_reset();
        id_ex_is_load = 1'b1; id_ex_reg_write = 1'b1; id_ex_wr_addr = 5'd4;
        id_src_addr   = {5'd4, 5'd4}; id_src_used = 2'b11;
        repeat (14) tick();
        n_checks++;
        if (stall_cnt !== 4'd14) begin
            n_fail++; $display("FAIL sat_count: got %0d want 14", stall_cnt);
        end
        repeat (6) tick();
        n_checks++;
        if (stall_cnt !== 4'd15) begin
            n_fail++; $display("FAIL sat_hold: got %0d want 15", stall_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        mul_start = 1'b1; mul_dst = 5'd9;
        tick();
        mul_start = 1'b0;
        id_src_addr = {5'd9, 5'd0}; id_src_used = 2'b10;
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mul_busy !== 1'b0 || mul_done !== 1'b0 || mul_wb_addr !== '0 || stall !== 1'b0 ||
            stall_cnt !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: got busy %b done %b wb %0d stall %b cnt %0d",
                     mul_busy, mul_done, mul_wb_addr, stall, stall_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_checks++;
            if (mul_done !== 1'b0 || mul_busy !== 1'b0) begin
                n_fail++; $display("FAIL rst_abort c%0d: got done %b busy %b want 0/0", c, mul_done, mul_busy);
            end
        end
        idle_inputs();
    endtask

    // Reference model: the op is remembered by the cycle it was issued, so busy
    // and done follow from the elapsed cycle count alone.
    task automatic test_random();
        int          cyc;
        bit          m_active;
        int          m_start;
        logic [4:0]  m_dst;
        bit          m_ovr;
        int          m_cnt;
        int          rel;
        bit          e_busy, e_done, e_stall, lu, ms;
        logic [3:0]  e_fwd;
        logic [1:0]  e_idf;
        logic [4:0]  e_wb;
        logic [4:0]  s;
        for (int blk = 0; blk < 6; blk++) begin
            do_reset();
            cyc = 0; m_active = 0; m_start = 0; m_dst = '0; m_ovr = 0; m_cnt = 0;
            for (int k = 0; k < 250; k++) begin
                ex_src_addr      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
                ex_mem_wr_addr   = 5'($urandom_range(0, 7));
                ex_mem_reg_write = 1'($urandom_range(0, 1));
                mem_wb_wr_addr   = 5'($urandom_range(0, 7));
                mem_wb_reg_write = 1'($urandom_range(0, 1));
                id_src_addr      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
                id_src_used      = 2'($urandom_range(0, 3));
                id_wr_addr       = 5'($urandom_range(0, 7));
                id_reg_write     = 1'($urandom_range(0, 1));
                id_is_mul        = ($urandom_range(0, 5) == 0);
                id_ex_wr_addr    = 5'($urandom_range(0, 7));
                id_ex_reg_write  = 1'($urandom_range(0, 1));
                id_ex_is_load    = ($urandom_range(0, 5) == 0);
                mul_start        = ($urandom_range(0, 4) == 0);
                mul_dst          = 5'($urandom_range(0, 7));
                #1;
                rel    = cyc - m_start;
                e_busy = m_active && rel < MUL_LAT;
                e_done = m_active && rel == MUL_LAT;
                e_wb   = e_done ? m_dst : 5'd0;
                for (int i = 0; i < 2; i++) begin
                    s = ex_src_addr[i*5 +: 5];
                    if (ex_mem_reg_write && ex_mem_wr_addr != 0 && ex_mem_wr_addr == s)
                        e_fwd[i*2 +: 2] = 2'b10;
                    else if (mem_wb_reg_write && mem_wb_wr_addr != 0 && mem_wb_wr_addr == s)
                        e_fwd[i*2 +: 2] = 2'b01;
                    else
                        e_fwd[i*2 +: 2] = 2'b00;
                end
                lu = 0; ms = e_busy && id_is_mul;
                for (int i = 0; i < 2; i++) begin
                    s = id_src_addr[i*5 +: 5];
                    if (id_ex_is_load && id_ex_reg_write && id_ex_wr_addr != 0 &&
                        id_src_used[i] && s == id_ex_wr_addr) lu = 1;
                    if (e_busy && id_src_used[i] && m_dst != 0 && s == m_dst) ms = 1;
                    e_idf[i] = e_done && id_src_used[i] && m_dst != 0 && s == m_dst;
                end
                if (e_busy && id_reg_write && m_dst != 0 && id_wr_addr == m_dst) ms = 1;
                e_stall = lu || ms;
                n_checks++;
                if (fwd_sel !== e_fwd || id_fwd_mul !== e_idf || stall !== e_stall) begin
                    n_fail++;
                    $display("FAIL rnd_comb cyc%0d: got fwd %b idf %b stall %b want %b %b %b",
                             cyc, fwd_sel, id_fwd_mul, stall, e_fwd, e_idf, e_stall);
                end
                n_checks++;
                if (mul_busy !== e_busy || mul_done !== e_done || mul_wb_addr !== e_wb ||
                    mul_overrun !== m_ovr || stall_cnt !== 4'(m_cnt)) begin
                    n_fail++;
                    $display("FAIL rnd_seq cyc%0d: got b%b d%b wb%0d o%b c%0d want b%b d%b wb%0d o%b c%0d",
                             cyc, mul_busy, mul_done, mul_wb_addr, mul_overrun, stall_cnt,
                             e_busy, e_done, e_wb, m_ovr, m_cnt);
                end
                // Model update for the coming clock edge.
                if (e_stall && m_cnt < 15) m_cnt++;
                if (mul_start && e_busy) begin
                    m_ovr = 1;
                end else if (mul_start) begin
                    m_active = 1; m_start = cyc; m_dst = mul_dst;
                end else if (m_active && rel >= MUL_LAT) begin
                    m_active = 0;
                end
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #12;
        test_reset();
        test_fwd();
        test_load_use();
        test_mul_basic();
        test_back_to_back();
        test_overrun();
        test_waw_struct();
        test_stall_sat();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the 5-stage pipeline. It generalises EX-stage operand forwarding to NUM_SRC source operands.
- Adds load-use stall detection and a scoreboard for one outstanding multi-cycle multiplier op, with ID-stage forwarding of the multiplier result.
- Adds a saturating stall-cycle counter.
- Sits beside the ID/EX pipeline registers. Drives the EX operand muxes, the ID operand muxes and the PC/IF-ID hold.

Parameters:
ADDR_W, 5, register address width
NUM_SRC, 2, source operands per instruction
MUL_LAT, 4, multiplier latency in cycles (legal >= 2)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ex_src_addr  in  NUM_SRC*ADDR_W  source addresses of instruction in EX (ID/EX regs), operand i at [i*ADDR_W +: ADDR_W]
ex_mem_wr_addr  in  ADDR_W  EX/MEM destination
ex_mem_reg_write  in  1  EX/MEM RegWrite
mem_wb_wr_addr  in  ADDR_W  MEM/WB destination
mem_wb_reg_write  in  1  MEM/WB RegWrite
id_src_addr  in  NUM_SRC*ADDR_W  source addresses of instruction in ID
id_src_used  in  NUM_SRC  operand i actually read
id_wr_addr  in  ADDR_W  ID destination
id_reg_write  in  1  ID instruction writes a register
id_is_mul  in  1  ID instruction is a multiplier op
id_ex_wr_addr  in  ADDR_W  ID/EX destination
id_ex_reg_write  in  1  ID/EX RegWrite
id_ex_is_load  in  1  ID/EX is a load
mul_start  in  1  multiplier op leaving EX this cycle, already qualified by pipeline
mul_dst  in  ADDR_W  destination of that op
fwd_sel  out  NUM_SRC*2  EX mux select per operand: 00 regfile, 10 EX/MEM, 01 MEM/WB
id_fwd_mul  out  NUM_SRC  ID operand i takes multiplier result
stall  out  1  hold PC and IF/ID, bubble ID/EX
mul_busy  out  1  scoreboard in RUN
mul_done  out  1  multiplier result valid this cycle
mul_wb_addr  out  ADDR_W  destination for mul result writeback
mul_overrun  out  1  sticky: mul_start seen while RUN
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (async, rst_n=0): state IDLE, dst 0, mul_done 0, mul_busy 0, mul_wb_addr 0, mul_overrun 0, stall_cnt 0.
- fwd_sel per operand i (combinational):
  - 10 if ex_mem_reg_write, ex_mem_wr_addr!=0 and ex_mem_wr_addr==src_i.
  - Else 01 if mem_wb_reg_write, mem_wb_wr_addr!=0 and mem_wb_wr_addr==src_i.
  - Else 00.
  - EX/MEM strictly wins on a double match.
- Load-use stall: id_ex_is_load, id_ex_reg_write, id_ex_wr_addr!=0, and any i with id_src_used[i] and id_src_addr_i==id_ex_wr_addr. Lasts exactly one cycle per occurrence.
- Scoreboard FSM, states IDLE, RUN, DONE:
  - Start is accepted in IDLE or DONE when mul_start=1: dst<=mul_dst, cnt<=MUL_LAT-1, next RUN.
  - RUN: cnt decrements each cycle. At cnt==1 the next state is DONE.
  - DONE: lasts one cycle. Next is IDLE, or RUN on an accepted start.
  - mul_start at cycle t gives mul_done=1 at t+MUL_LAT, exactly one cycle wide. Back-to-back starts are allowed in the DONE cycle.
  - mul_start in RUN is ignored (state, dst and cnt unchanged) and sets mul_overrun until reset.
- Outputs from FSM state:
  - mul_busy = (state==RUN).
  - mul_done = (state==DONE).
  - mul_wb_addr = dst while DONE, else 0.
- Multiplier stall while RUN if any of the following holds:
  - RAW: id_src_used[i], dst!=0, id_src_addr_i==dst.
  - WAW: id_reg_write, dst!=0, id_wr_addr==dst.
  - Structural: id_is_mul.
- id_fwd_mul[i] = DONE and id_src_used[i] and dst!=0 and id_src_addr_i==dst. No stall is raised in DONE.
- stall = load-use OR multiplier stall (combinational).
- stall_cnt increments on each clk edge with stall=1 and saturates at all-ones.
- Address 0 never forwards or stalls.
- Asserting reset mid-RUN aborts the op: no mul_done is issued.

Test Plan:
- EX/MEM wr=5 (RegWrite=1), MEM/WB wr=5 (RegWrite=1), ex_src0=5 -> fwd_sel[1:0]=10. With ex_mem_reg_write=0 -> 01. With both addresses 0 and src0=0 -> 00.
- ID/EX load to r7, id_src1=7 used -> stall=1 for one cycle, stall_cnt 0->1. Same case with id_src_used[1]=0 -> stall=0.
- MUL_LAT=4, mul_start dst=9 at cycle 0 -> mul_busy cycles 1-3, mul_done and mul_wb_addr=9 at cycle 4. ID reading r9 -> stall cycles 1-3, id_fwd_mul=1 at cycle 4.
- mul_start at the DONE cycle with dst=3 -> new mul_done at +4 with mul_wb_addr=3. mul_start during RUN -> ignored, mul_overrun=1.
- WAW (id_wr_addr==dst) and id_is_mul during RUN -> stall=1. Drive stall continuously with CNT_W=4 -> stall_cnt holds at 15.
- rst_n low at cycle 2 of RUN -> all outputs 0 immediately, no mul_done follows.
